// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// mem_stage_if : valid/ready data-memory bus between the MEM stage and memory
// Revision     : 1.0
// ============================================================================
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline MEM stage - data-memory access, load extend, MEM/WB regs
// Revision  : 1.0
// ============================================================================
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] EX_MEM_ALU_result,
    input  logic [31:0] EX_MEM_rs2_data,
    input  logic [2:0]  EX_MEM_funct3,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_regwrite,
    input  logic        EX_MEM_memtoreg,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [31:0] MEM_WB_ALU_result,
    output logic [31:0] MEM_WB_mem_data,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic        MEM_WB_memtoreg
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;

    logic [31:0] r_alu;
    logic [31:0] r_rs2;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_regwrite;
    logic        r_memtoreg;
    logic        r_we;

    logic [31:0] w_alu;
    logic [31:0] w_rs2;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic        w_regwrite;
    logic        w_memtoreg;
    logic        w_we;
    logic        w_access;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic [31:0] w_load_data;

    logic        w_req;
    logic        w_stall;
    logic        w_complete;
    logic        w_fault;
    logic        w_latch;

    // The operation being served: live EX_MEM fields in IDLE, the latched copy in WAIT
    assign w_alu      = (r_state == S_WAIT) ? r_alu      : EX_MEM_ALU_result;
    assign w_rs2      = (r_state == S_WAIT) ? r_rs2      : EX_MEM_rs2_data;
    assign w_funct3   = (r_state == S_WAIT) ? r_funct3   : EX_MEM_funct3;
    assign w_rd       = (r_state == S_WAIT) ? r_rd       : EX_MEM_rd;
    assign w_regwrite = (r_state == S_WAIT) ? r_regwrite : EX_MEM_regwrite;
    assign w_memtoreg = (r_state == S_WAIT) ? r_memtoreg : EX_MEM_memtoreg;
    assign w_we       = (r_state == S_WAIT) ? r_we       : EX_MEM_memwrite;
    assign w_access   = (r_state == S_WAIT) ? 1'b1
                                            : (EX_MEM_memread | EX_MEM_memwrite);

    always_comb begin
        w_be       = 4'b0000;
        w_wdata    = w_rs2;
        w_misalign = 1'b0;
        case (w_funct3)
            3'b000, 3'b100: begin
                w_be    = 4'b0001 << w_alu[1:0];
                w_wdata = {4{w_rs2[7:0]}};
            end
            3'b001, 3'b101: begin
                w_be       = 4'b0011 << w_alu[1:0];
                w_wdata    = {2{w_rs2[15:0]}};
                w_misalign = w_alu[0];
            end
            3'b010: begin
                w_be       = 4'b1111;
                w_misalign = |w_alu[1:0];
            end
            default: w_misalign = 1'b1;
        endcase
    end

    always_comb begin
        w_byte = dmem.rdata[7:0];
        case (w_alu[1:0])
            2'd0: w_byte = dmem.rdata[7:0];
            2'd1: w_byte = dmem.rdata[15:8];
            2'd2: w_byte = dmem.rdata[23:16];
            2'd3: w_byte = dmem.rdata[31:24];
            default: w_byte = dmem.rdata[7:0];
        endcase
        w_half = w_alu[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (w_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem.rdata;
        endcase
        // Stores and non-memory ops carry zero load data
        w_load_data = (w_access && !w_we) ? w_ext : 32'd0;
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_req      = 1'b0;
        w_stall    = 1'b0;
        w_complete = 1'b0;
        w_fault    = 1'b0;
        w_latch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_access) begin
                    w_complete = 1'b1;
                end else if (w_misalign) begin
                    w_fault = 1'b1;
                end else begin
                    w_req = 1'b1;
                    if (dmem.ready) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall    = 1'b1;
                        w_latch    = 1'b1;
                        w_cnt_next = 16'd0;
                        w_next     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (dmem.ready) begin
                    w_complete = 1'b1;
                    w_next     = S_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    // Abort cycle: upstream is released now, bubble + fault at the edge
                    w_fault = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request and stall are masked by reset so an in-flight access vanishes at once
    assign dmem.req   = w_req & reset;
    assign mem_stall  = w_stall & reset;
    assign dmem.we    = w_we;
    assign dmem.addr  = {w_alu[31:2], 2'b00};
    assign dmem.wdata = w_wdata;
    assign dmem.be    = w_be;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_cnt             <= 16'd0;
            r_alu             <= 32'd0;
            r_rs2             <= 32'd0;
            r_funct3          <= 3'd0;
            r_rd              <= 5'd0;
            r_regwrite        <= 1'b0;
            r_memtoreg        <= 1'b0;
            r_we              <= 1'b0;
            mem_fault         <= 1'b0;
            MEM_WB_ALU_result <= 32'd0;
            MEM_WB_mem_data   <= 32'd0;
            MEM_WB_rd         <= 5'd0;
            MEM_WB_regwrite   <= 1'b0;
            MEM_WB_memtoreg   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            mem_fault <= w_fault;
            if (w_latch) begin
                r_alu      <= EX_MEM_ALU_result;
                r_rs2      <= EX_MEM_rs2_data;
                r_funct3   <= EX_MEM_funct3;
                r_rd       <= EX_MEM_rd;
                r_regwrite <= EX_MEM_regwrite;
                r_memtoreg <= EX_MEM_memtoreg;
                r_we       <= EX_MEM_memwrite;
            end
            if (w_complete) begin
                MEM_WB_ALU_result <= w_alu;
                MEM_WB_mem_data   <= w_load_data;
                MEM_WB_rd         <= w_rd;
                MEM_WB_regwrite   <= w_regwrite;
                MEM_WB_memtoreg   <= w_memtoreg;
            end else begin
                MEM_WB_ALU_result <= 32'd0;
                MEM_WB_mem_data   <= 32'd0;
                MEM_WB_rd         <= 5'd0;
                MEM_WB_regwrite   <= 1'b0;
                MEM_WB_memtoreg   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : scoreboard bench for mem_stage (TIMEOUT_CYCLES = 4)
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;

    localparam int unsigned C_TIMEOUT = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ex_alu;
    logic [31:0] ex_rs2;
    logic [2:0]  ex_f3;
    logic [4:0]  ex_rd;
    logic        ex_rw;
    logic        ex_m2r;
    logic        ex_mr;
    logic        ex_mw;
    logic        stall;
    logic        fault;
    logic [31:0] wb_alu;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic        wb_m2r;

    mem_stage_if dmem();

    mem_stage #(.TIMEOUT_CYCLES(C_TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .EX_MEM_ALU_result (ex_alu),
        .EX_MEM_rs2_data   (ex_rs2),
        .EX_MEM_funct3     (ex_f3),
        .EX_MEM_rd         (ex_rd),
        .EX_MEM_regwrite   (ex_rw),
        .EX_MEM_memtoreg   (ex_m2r),
        .EX_MEM_memread    (ex_mr),
        .EX_MEM_memwrite   (ex_mw),
        .dmem              (dmem.master),
        .mem_stall         (stall),
        .mem_fault         (fault),
        .MEM_WB_ALU_result (wb_alu),
        .MEM_WB_mem_data   (wb_data),
        .MEM_WB_rd         (wb_rd),
        .MEM_WB_regwrite   (wb_rw),
        .MEM_WB_memtoreg   (wb_m2r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic drive_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                            input logic [4:0] rd, input logic rw, input logic m2r,
                            input logic mr, input logic mw);
        ex_alu = alu; ex_rs2 = rs2; ex_f3 = f3; ex_rd = rd;
        ex_rw = rw; ex_m2r = m2r; ex_mr = mr; ex_mw = mw;
    endtask

    task automatic set_nop();
        drive_op(32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sb_pop_compare(input string tag);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got a result with alu=%h, expected queue empty", tag, wb_alu);
        end else begin
            e = exp_q.pop_front();
            if (wb_alu !== e.alu || wb_data !== e.data || wb_rd !== e.rd ||
                wb_rw !== e.rw || wb_m2r !== e.m2r) begin
                n_fail++;
                $display("FAIL %s writeback: got alu=%h data=%h rd=%0d rw=%b m2r=%b, exp alu=%h data=%h rd=%0d rw=%b m2r=%b",
                         tag, wb_alu, wb_data, wb_rd, wb_rw, wb_m2r, e.alu, e.data, e.rd, e.rw, e.m2r);
            end
        end
    endtask

    // Aligned access answered after 'waits' ready=0 cycles; EX_MEM is scrambled while in WAIT
    task automatic do_mem(input string tag, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [2:0] f3, input logic [4:0] rd, input logic rw, input logic m2r,
                          input logic mr, input logic mw, input int waits, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data);
        logic [31:0] exp_addr;
        exp_addr = {alu[31:2], 2'b00};
        @(negedge clk);
        drive_op(alu, rs2, f3, rd, rw, m2r, mr, mw);
        dmem.ready = (waits == 0);
        dmem.rdata = rdata;
        exp_q.push_back('{alu, exp_data, rd, rw, m2r});
        for (int k = 0; k <= waits; k++) begin
            #1;
            n_checks++;
            if (dmem.req !== 1'b1 || dmem.we !== mw || dmem.addr !== exp_addr ||
                dmem.be !== exp_be || dmem.wdata !== exp_wdata) begin
                n_fail++;
                $display("FAIL %s bus c%0d: got req=%b we=%b addr=%h be=%b wdata=%h, exp req=1 we=%b addr=%h be=%b wdata=%h",
                         tag, k, dmem.req, dmem.we, dmem.addr, dmem.be, dmem.wdata, mw, exp_addr, exp_be, exp_wdata);
            end
            n_checks++;
            if (stall !== (k < waits)) begin
                n_fail++;
                $display("FAIL %s stall c%0d: got %b exp %b", tag, k, stall, (k < waits));
            end
            @(posedge clk); #1;
            n_checks++;
            if (fault !== 1'b0) begin
                n_fail++;
                $display("FAIL %s fault c%0d: got %b exp 0", tag, k, fault);
            end
            if (k < waits) begin
                n_checks++;
                if (wb_rw !== 1'b0 || wb_rd !== 5'd0) begin
                    n_fail++;
                    $display("FAIL %s bubble c%0d: got rw=%b rd=%0d exp rw=0 rd=0", tag, k, wb_rw, wb_rd);
                end
                @(negedge clk);
                dmem.ready = (k + 1 == waits);
                drive_op(~alu, ~rs2, 3'b011, ~rd, ~rw, ~m2r, 1'b0, 1'b0);
            end else begin
                sb_pop_compare(tag);
            end
        end
        dmem.ready = 1'b0;
    endtask

    task automatic do_alu(input string tag, input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        @(negedge clk);
        drive_op(alu, 32'hA5A5_5A5A, 3'b010, rd, rw, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{alu, 32'd0, rd, rw, 1'b0});
        #1;
        n_checks++;
        if (dmem.req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s no-access: got req=%b stall=%b exp req=0 stall=0", tag, dmem.req, stall);
        end
        @(posedge clk); #1;
        sb_pop_compare(tag);
    endtask

    task automatic do_misalign(input string tag, input logic [31:0] alu, input logic [2:0] f3,
                               input logic mr, input logic mw);
        @(negedge clk);
        drive_op(alu, 32'h1111_2222, f3, 5'd9, 1'b1, mr, mr, mw);
        dmem.ready = 1'b1;
        #1;
        n_checks++;
        if (dmem.req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s misalign bus: got req=%b stall=%b exp req=0 stall=0", tag, dmem.req, stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (fault !== 1'b1 || wb_rw !== 1'b0 || wb_rd !== 5'd0 || wb_m2r !== 1'b0) begin
            n_fail++;
            $display("FAIL %s misalign wb: got fault=%b rw=%b rd=%0d m2r=%b exp fault=1 rw=0 rd=0 m2r=0",
                     tag, fault, wb_rw, wb_rd, wb_m2r);
        end
        @(negedge clk);
        set_nop();
        dmem.ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL %s fault pulse: got %b exp 0 one cycle later", tag, fault);
        end
    endtask

    task automatic test_reset();
        set_nop();
        dmem.ready = 1'b0;
        dmem.rdata = 32'd0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (wb_alu !== 32'd0 || wb_data !== 32'd0 || wb_rd !== 5'd0 || wb_rw !== 1'b0 ||
            wb_m2r !== 1'b0 || fault !== 1'b0 || dmem.req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got alu=%h data=%h rd=%0d rw=%b m2r=%b fault=%b req=%b exp all 0",
                     wb_alu, wb_data, wb_rd, wb_rw, wb_m2r, fault, dmem.req);
        end
        @(negedge clk);
        reset = 1'b1;
        // Enter WAIT with a load, then pull reset low in the middle of the wait
        @(negedge clk);
        drive_op(32'h0000_0080, 32'd0, 3'b010, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (dmem.req !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_setup: got req=%b stall=%b exp req=1 stall=1", dmem.req, stall);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (dmem.req !== 1'b0 || stall !== 1'b0 || wb_rw !== 1'b0 || wb_rd !== 5'd0 ||
            wb_alu !== 32'd0 || wb_data !== 32'd0 || wb_m2r !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got req=%b stall=%b rw=%b rd=%0d alu=%h data=%h exp all 0",
                     dmem.req, stall, wb_rw, wb_rd, wb_alu, wb_data);
        end
        @(negedge clk);
        drive_op(32'h0000_1234, 32'd0, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (wb_rd !== 5'd5 || wb_alu !== 32'h0000_1234 || wb_rw !== 1'b1 || wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release: got rd=%0d alu=%h rw=%b data=%h exp rd=5 alu=00001234 rw=1 data=0",
                     wb_rd, wb_alu, wb_rw, wb_data);
        end
    endtask

    task automatic test_load_extract();
        do_mem("lb",  32'h0000_0103, 32'd0, 3'b000, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 0,
               32'h80FF_FF00, 4'b1000, 32'd0, 32'hFFFF_FF80);
        do_mem("lbu", 32'h0000_0103, 32'd0, 3'b100, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 0,
               32'h80FF_FF00, 4'b1000, 32'd0, 32'h0000_0080);
        do_mem("lh",  32'h0000_0102, 32'd0, 3'b001, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 0,
               32'h80FF_FF00, 4'b1100, 32'd0, 32'hFFFF_80FF);
        do_mem("lhu", 32'h0000_0100, 32'd0, 3'b101, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 0,
               32'h80FF_FF00, 4'b0011, 32'd0, 32'h0000_FF00);
        do_mem("lw",  32'h0000_0104, 32'd0, 3'b010, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1,
               32'h1234_5678, 4'b1111, 32'd0, 32'h1234_5678);
    endtask

    task automatic test_store();
        do_mem("sh",  32'h0000_0202, 32'hDEAD_BEEF, 3'b001, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3,
               32'h0, 4'b1100, 32'hBEEF_BEEF, 32'd0);
        do_mem("sb",  32'h0000_0201, 32'h0000_00AB, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1,
               32'h0, 4'b0010, 32'hABAB_ABAB, 32'd0);
        do_mem("rw_both", 32'h0000_0300, 32'h0102_0304, 3'b010, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 0,
               32'hFFFF_FFFF, 4'b1111, 32'h0102_0304, 32'd0);
    endtask

    task automatic test_misalign();
        do_misalign("lw_105",  32'h0000_0105, 3'b010, 1'b1, 1'b0);
        do_misalign("lh_101",  32'h0000_0101, 3'b001, 1'b1, 1'b0);
        do_misalign("illegal", 32'h0000_0100, 3'b011, 1'b1, 1'b0);
        do_misalign("sh_203",  32'h0000_0203, 3'b001, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        drive_op(32'h0000_0040, 32'd0, 3'b010, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        dmem.ready = 1'b0;
        #1;
        n_checks++;
        if (dmem.req !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_idle: got req=%b stall=%b exp req=1 stall=1", dmem.req, stall);
        end
        @(posedge clk);
        for (int w = 0; w < int'(C_TIMEOUT); w++) begin
            @(negedge clk);
            set_nop();
            #1;
            n_checks++;
            if (dmem.req !== 1'b1 || dmem.addr !== 32'h0000_0040 || stall !== (w < int'(C_TIMEOUT) - 1)) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: got req=%b addr=%h stall=%b exp req=1 addr=00000040 stall=%b",
                         w, dmem.req, dmem.addr, stall, (w < int'(C_TIMEOUT) - 1));
            end
            @(posedge clk); #1;
            n_checks++;
            if (w < int'(C_TIMEOUT) - 1) begin
                if (fault !== 1'b0 || wb_rw !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_hold%0d: got fault=%b rw=%b exp 0 0", w, fault, wb_rw);
                end
            end else if (fault !== 1'b1 || dmem.req !== 1'b0 || wb_rw !== 1'b0 || wb_rd !== 5'd0) begin
                n_fail++;
                $display("FAIL timeout_abort: got fault=%b req=%b rw=%b rd=%0d exp fault=1 req=0 rw=0 rd=0",
                         fault, dmem.req, wb_rw, wb_rd);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got fault=%b exp 0", fault);
        end
    endtask

    task automatic test_back_to_back();
        do_mem("b2b_lw", 32'h0000_0010, 32'd0, 3'b010, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2,
               32'hCAFE_F00D, 4'b1111, 32'd0, 32'hCAFE_F00D);
        do_alu("b2b_add", 32'h0000_0077, 5'd7, 1'b1);
        do_alu("rd0_pass", 32'h0000_0099, 5'd0, 1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left exp 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_extract();
        test_store();
        test_misalign();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
